axis_sample_packetizer: RTL

//  Framing stage directly upstream of axis_data_to_chdr. Takes a raw item stream, cuts it into

---
 rtl/axis_sample_packetizer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/axis_sample_packetizer.sv
// Framing stage ahead of the CHDR packer: cuts a raw item stream into fixed-length packets
// and attaches first-beat sideband (length, timestamp, end-of-burst) held for the whole packet.
module axis_sample_packetizer #(
  parameter int ITEM_W  = 32,
  parameter int SPP_MAX = 256,
  parameter int LEN_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [15:0]       spp_i,
  input  logic [63:0]       time_i,
  input  logic              has_time_i,
  input  logic              eob_req_i,
  input  logic [ITEM_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [ITEM_W-1:0] m_axis_tdata,
  output logic              m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [63:0]       m_axis_ttimestamp,
  output logic              m_axis_thas_time,
  output logic [LEN_W-1:0]  m_axis_tlength,
  output logic              m_axis_teov,
  output logic              m_axis_teob,
  output logic              busy_o,
  output logic [31:0]       pkt_cnt_o
);

  localparam int          SPP_W      = $clog2(SPP_MAX) + 1;
  localparam logic [31:0] ITEM_BYTES = 32'(ITEM_W / 8);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic              enPrev_q, enPrev_d;
  logic [SPP_W-1:0]  sppR_q, sppR_d;
  logic [63:0]       tsR_q, tsR_d;
  logic              hasTimeR_q, hasTimeR_d;
  logic [SPP_W-1:0]  itemCnt_q, itemCnt_d;
  logic              eobPend_q, eobPend_d;
  logic [ITEM_W-1:0] mData_q, mData_d;
  logic              mValid_q, mValid_d;
  logic              mLast_q, mLast_d;
  logic [63:0]       mTs_q, mTs_d;
  logic              mHasTime_q, mHasTime_d;
  logic [LEN_W-1:0]  mLen_q, mLen_d;
  logic              mEob_q, mEob_d;
  logic [31:0]       pktCnt_q, pktCnt_d;

  logic sReady, accept, outFire, eobNow, lastItem;

  // Once the final packet's tlast sits in the output register, no further items may enter.
  assign sReady   = (state_q == RUN) && (!mValid_q || m_axis_tready) &&
                    !(mValid_q && mLast_q && mEob_q);
  assign accept   = s_axis_tvalid && sReady;
  assign outFire  = mValid_q && m_axis_tready;
  assign eobNow   = eob_req_i || (enPrev_q && !en_i);
  assign lastItem = (itemCnt_q == (sppR_q - SPP_W'(1)));

  always_comb begin
    state_d    = state_q;
    enPrev_d   = en_i;
    sppR_d     = sppR_q;
    tsR_d      = tsR_q;
    hasTimeR_d = hasTimeR_q;
    itemCnt_d  = itemCnt_q;
    eobPend_d  = eobPend_q;
    mData_d    = mData_q;
    mValid_d   = mValid_q;
    mLast_d    = mLast_q;
    mTs_d      = mTs_q;
    mHasTime_d = mHasTime_q;
    mLen_d     = mLen_q;
    mEob_d     = mEob_q;
    pktCnt_d   = pktCnt_q;

    if (outFire) begin
      mValid_d = 1'b0;
      if (mLast_q) pktCnt_d = pktCnt_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        if (en_i && !enPrev_q) begin
          state_d = RUN;
          if (spp_i == 16'd0 || 32'(spp_i) > 32'(SPP_MAX)) sppR_d = SPP_W'(SPP_MAX);
          else                                              sppR_d = SPP_W'(spp_i);
          tsR_d      = time_i;
          hasTimeR_d = has_time_i;
          itemCnt_d  = '0;
          eobPend_d  = 1'b0;
        end
      end
      RUN: begin
        if (eobNow) eobPend_d = 1'b1;
        if (accept) begin
          mData_d   = s_axis_tdata;
          mValid_d  = 1'b1;
          mLast_d   = lastItem;
          tsR_d     = tsR_q + 64'd1;
          itemCnt_d = lastItem ? '0 : itemCnt_q + SPP_W'(1);
          // Packet sideband is frozen at the first item and held for every beat.
          if (itemCnt_q == '0) begin
            mTs_d      = tsR_q;
            mHasTime_d = hasTimeR_q;
            mLen_d     = LEN_W'(32'(sppR_q) * ITEM_BYTES);
            mEob_d     = eobPend_q || eob_req_i || !en_i;
          end
        end
        if (outFire && mLast_q && mEob_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      enPrev_q   <= 1'b0;
      sppR_q     <= '0;
      tsR_q      <= '0;
      hasTimeR_q <= 1'b0;
      itemCnt_q  <= '0;
      eobPend_q  <= 1'b0;
      mData_q    <= '0;
      mValid_q   <= 1'b0;
      mLast_q    <= 1'b0;
      mTs_q      <= '0;
      mHasTime_q <= 1'b0;
      mLen_q     <= '0;
      mEob_q     <= 1'b0;
      pktCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      enPrev_q   <= enPrev_d;
      sppR_q     <= sppR_d;
      tsR_q      <= tsR_d;
      hasTimeR_q <= hasTimeR_d;
      itemCnt_q  <= itemCnt_d;
      eobPend_q  <= eobPend_d;
      mData_q    <= mData_d;
      mValid_q   <= mValid_d;
      mLast_q    <= mLast_d;
      mTs_q      <= mTs_d;
      mHasTime_q <= mHasTime_d;
      mLen_q     <= mLen_d;
      mEob_q     <= mEob_d;
      pktCnt_q   <= pktCnt_d;
    end
  end

  assign s_axis_tready     = sReady;
  assign m_axis_tdata      = mData_q;
  assign m_axis_tkeep      = 1'b1;
  assign m_axis_tlast      = mLast_q;
  assign m_axis_tvalid     = mValid_q;
  assign m_axis_ttimestamp = mTs_q;
  assign m_axis_thas_time  = mHasTime_q;
  assign m_axis_tlength    = mLen_q;
  assign m_axis_teob       = mEob_q;
  assign m_axis_teov       = mEob_q;
  assign busy_o            = (state_q != IDLE);
  assign pkt_cnt_o         = pktCnt_q;

endmodule
